// File: rtl/rf_wb_arbiter_if.sv
// Writeback request channel: one valid/ready handshake carrying a
// destination register and its data. Master = requester, slave = arbiter.
//   valid : request present      ready : FIFO has room (state only)
//   addr  : destination register data  : write data
interface rf_wb_arbiter_if;
   logic        valid;
   logic        ready;
   logic [4:0]  addr;
   logic [31:0] data;

   modport master (
      output valid,
      output addr,
      output data,
      input  ready
   );

   modport slave (
      input  valid,
      input  addr,
      input  data,
      output ready
   );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter for two writeback sources, each with
// its own holding FIFO, a registered output stage and a RAW-hazard query.
// Ports: clk, rst_n (async, active-low); a_if/b_if writeback channels
// (A = ALU path, B = multi-cycle path); Reg_w/Rd_addr/Rd_data register
// file write (registered); q_addr/q_pending hazard query (combinational).
// Build option: RF_WB_RR_ARB_EN selects round-robin arbitration; when it
// is undefined port A has fixed priority over port B.
module rf_wb_arbiter #(
   parameter int BUF_DEPTH = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   rf_wb_arbiter_if.slave a_if,
   rf_wb_arbiter_if.slave b_if,
   output logic           Reg_w,
   output logic [4:0]     Rd_addr,
   output logic [31:0]    Rd_data,
   input  logic [4:0]     q_addr,
   output logic           q_pending
);
   localparam int PW = $clog2(BUF_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

   // index 0 = port A, index 1 = port B
   logic [4:0]    addr_q [2][BUF_DEPTH];
   logic [31:0]   data_q [2][BUF_DEPTH];
   logic [PW-1:0] rd_ptr_q [2];
   logic [PW-1:0] rd_ptr_d [2];
   logic [PW-1:0] wr_ptr_q [2];
   logic [PW-1:0] wr_ptr_d [2];
   logic [CW-1:0] cnt_q [2];
   logic [CW-1:0] cnt_d [2];

   logic [1:0]    valid;
   logic [1:0]    ready;
   logic [1:0]    push;
   logic [1:0]    pop;
   logic [1:0]    nempty;
   logic [4:0]    in_addr [2];
   logic [31:0]   in_data [2];

   logic          reg_w_q;
   logic          reg_w_d;
   logic [4:0]    rd_addr_q;
   logic [4:0]    rd_addr_d;
   logic [31:0]   rd_data_q;
   logic [31:0]   rd_data_d;
   logic [4:0]    head_addr;
   logic [31:0]   head_data;
   logic          pend_buf;
   logic [PW-1:0] off;

   assign valid      = {b_if.valid, a_if.valid};
   assign in_addr[0] = a_if.addr;
   assign in_addr[1] = b_if.addr;
   assign in_data[0] = a_if.data;
   assign in_data[1] = b_if.data;
   assign a_if.ready = ready[0];
   assign b_if.ready = ready[1];

   // ready depends on the pre-edge count only, so a full FIFO that pops
   // this cycle still refuses a new entry until the next cycle.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         ready[p]  = (cnt_q[p] != FULL);
         nempty[p] = (cnt_q[p] != '0);
      end
   end

   assign push = valid & ready;

`ifdef RF_WB_RR_ARB_EN
   // rr_q = 0: A preferred on the next contended cycle, 1: B preferred
   logic rr_q;
   logic rr_d;

   always_comb begin
      pop  = nempty;
      rr_d = rr_q;
      if (&nempty) begin
         pop  = rr_q ? 2'b10 : 2'b01;
         rr_d = ~rr_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q <= 1'b0;
      end else begin
         rr_q <= rr_d;
      end
   end
`else
   always_comb begin
      pop = 2'b00;
      if (nempty[0]) begin
         pop = 2'b01;
      end else if (nempty[1]) begin
         pop = 2'b10;
      end
   end
`endif

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_ptr_d[p] = rd_ptr_q[p] + PW'(pop[p]);
         wr_ptr_d[p] = wr_ptr_q[p] + PW'(push[p]);
         cnt_d[p]    = cnt_q[p] + CW'(push[p]) - CW'(pop[p]);
      end
   end

   always_comb begin
      if (pop[1]) begin
         head_addr = addr_q[1][rd_ptr_q[1]];
         head_data = data_q[1][rd_ptr_q[1]];
      end else begin
         head_addr = addr_q[0][rd_ptr_q[0]];
         head_data = data_q[0][rd_ptr_q[0]];
      end
   end

   // R0 writes drain through the stage with the enable held low
   always_comb begin
      reg_w_d   = 1'b0;
      rd_addr_d = rd_addr_q;
      rd_data_d = rd_data_q;
      if (|pop) begin
         reg_w_d   = (head_addr != 5'd0);
         rd_addr_d = head_addr;
         rd_data_d = head_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int p = 0; p < 2; p++) begin
            rd_ptr_q[p] <= '0;
            wr_ptr_q[p] <= '0;
            cnt_q[p]    <= '0;
         end
         reg_w_q   <= 1'b0;
         rd_addr_q <= '0;
         rd_data_q <= '0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            rd_ptr_q[p] <= rd_ptr_d[p];
            wr_ptr_q[p] <= wr_ptr_d[p];
            cnt_q[p]    <= cnt_d[p];
         end
         reg_w_q   <= reg_w_d;
         rd_addr_q <= rd_addr_d;
         rd_data_q <= rd_data_d;
      end
   end

   // Storage needs no reset: occupancy is tracked by the counters.
   always_ff @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
         if (push[p]) begin
            addr_q[p][wr_ptr_q[p]] <= in_addr[p];
            data_q[p][wr_ptr_q[p]] <= in_data[p];
         end
      end
   end

   // Slot i holds a live entry when its distance from the read pointer,
   // taken modulo the depth, is below the occupancy count.
   always_comb begin
      pend_buf = 1'b0;
      off      = '0;
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            off = PW'(i) - rd_ptr_q[p];
            if (({1'b0, off} < cnt_q[p]) && (addr_q[p][i] == q_addr)) begin
               pend_buf = 1'b1;
            end
         end
      end
   end

   assign q_pending = (q_addr != 5'd0) &&
                      (pend_buf || (reg_w_q && (rd_addr_q == q_addr)));

   assign Reg_w   = reg_w_q;
   assign Rd_addr = rd_addr_q;
   assign Rd_data = rd_data_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Testbench for rf_wb_arbiter: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_rf_wb_arbiter;
   localparam int DEPTH = 2;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   logic        clk;
   logic        rst_n;
   logic        Reg_w;
   logic [4:0]  Rd_addr;
   logic [31:0] Rd_data;
   logic [4:0]  q_addr;
   logic        q_pending;

   rf_wb_arbiter_if a_if ();
   rf_wb_arbiter_if b_if ();

   rf_wb_arbiter #(.BUF_DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_if      (a_if),
      .b_if      (b_if),
      .Reg_w     (Reg_w),
      .Rd_addr   (Rd_addr),
      .Rd_data   (Rd_data),
      .q_addr    (q_addr),
      .q_pending (q_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errs   = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   ent_t        mqa[$];
   ent_t        mqb[$];
   logic        m_w;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   bit          m_pref_b;

   always @(posedge clk or negedge rst_n) begin
      bit   acc_a, acc_b, ga, gb;
      ent_t e;
      if (!rst_n) begin
         mqa.delete();
         mqb.delete();
         m_w      = 1'b0;
         m_addr   = '0;
         m_data   = '0;
         m_pref_b = 1'b0;
      end else begin
         acc_a = a_if.valid && (mqa.size() != DEPTH);
         acc_b = b_if.valid && (mqb.size() != DEPTH);
         ga = 1'b0;
         gb = 1'b0;
         e  = '0;
         if (mqa.size() != 0 && mqb.size() != 0) begin
`ifdef RF_WB_RR_ARB_EN
            if (m_pref_b) gb = 1'b1;
            else ga = 1'b1;
            m_pref_b = ga;
`else
            ga = 1'b1;
`endif
         end else if (mqa.size() != 0) begin
            ga = 1'b1;
         end else if (mqb.size() != 0) begin
            gb = 1'b1;
         end
         m_w = 1'b0;
         if (ga) e = mqa.pop_front();
         else if (gb) e = mqb.pop_front();
         if (ga || gb) begin
            m_w    = (e.a != 5'd0);
            m_addr = e.a;
            m_data = e.d;
         end
         if (acc_a) mqa.push_back({a_if.addr, a_if.data});
         if (acc_b) mqb.push_back({b_if.addr, b_if.data});
      end
   end

   function automatic bit m_pend();
      bit r;
      r = 1'b0;
      if (q_addr != 5'd0) begin
         foreach (mqa[i]) if (mqa[i].a == q_addr) r = 1'b1;
         foreach (mqb[i]) if (mqb[i].a == q_addr) r = 1'b1;
         if (m_w && m_addr == q_addr) r = 1'b1;
      end
      return r;
   endfunction

   always @(negedge clk) begin
      chk("Reg_w", 32'(Reg_w), 32'(m_w));
      chk("Rd_addr", 32'(Rd_addr), 32'(m_addr));
      chk("Rd_data", Rd_data, m_data);
      chk("a_ready", 32'(a_if.ready), 32'(mqa.size() != DEPTH));
      chk("b_ready", 32'(b_if.ready), 32'(mqb.size() != DEPTH));
      chk("q_pending", 32'(q_pending), 32'(m_pend()));
   end

   // register file and retirement log
   logic [31:0] rf [32];
   logic [4:0]  ret_a[$];
   logic [31:0] ret_d[$];

   always @(negedge clk) begin
      if (Reg_w) begin
         if (Rd_addr != 5'd0) rf[Rd_addr] <= Rd_data;
         ret_a.push_back(Rd_addr);
         ret_d.push_back(Rd_data);
      end
   end

   // ---------------- stimulus ----------------
   logic [4:0]  sa_a[$];
   logic [31:0] sa_d[$];
   logic [4:0]  sb_a[$];
   logic [31:0] sb_d[$];

   task automatic present(input int ia, input int ib);
      a_if.valid = (ia < sa_a.size());
      b_if.valid = (ib < sb_a.size());
      if (a_if.valid) begin
         a_if.addr = sa_a[ia];
         a_if.data = sa_d[ia];
      end
      if (b_if.valid) begin
         b_if.addr = sb_a[ib];
         b_if.data = sb_d[ib];
      end
   endtask

   task automatic stream(input int maxcyc);
      int   ia, ib, cyc;
      logic ra, rb;
      ia  = 0;
      ib  = 0;
      cyc = 0;
      @(posedge clk);
      #1;
      present(ia, ib);
      while ((ia < sa_a.size() || ib < sb_a.size()) && cyc < maxcyc) begin
         @(negedge clk);
         ra = a_if.ready;
         rb = b_if.ready;
         @(posedge clk);
         #1;
         if (a_if.valid && ra) ia++;
         if (b_if.valid && rb) ib++;
         present(ia, ib);
         cyc++;
      end
      chk("stream_timeout", 32'(cyc < maxcyc), 32'd1);
      a_if.valid = 1'b0;
      b_if.valid = 1'b0;
      repeat (24) @(negedge clk);
   endtask

   task automatic clear_stim();
      sa_a.delete();
      sa_d.delete();
      sb_a.delete();
      sb_d.delete();
      ret_a.delete();
      ret_d.delete();
   endtask

   initial begin
      logic [4:0]  exp_a[$];
      logic [31:0] got_a[$];
      logic [31:0] got_b[$];

      foreach (rf[i]) rf[i] = '0;
      rst_n      = 1'b0;
      a_if.valid = 1'b0;
      a_if.addr  = '0;
      a_if.data  = '0;
      b_if.valid = 1'b0;
      b_if.addr  = '0;
      b_if.data  = '0;
      q_addr     = 5'd0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_Reg_w", 32'(Reg_w), 32'd0);
      chk("rst_Rd_addr", 32'(Rd_addr), 32'd0);
      chk("rst_Rd_data", Rd_data, 32'd0);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_a_ready", 32'(a_if.ready), 32'd1);
      chk("rst_b_ready", 32'(b_if.ready), 32'd1);
      chk("rst_q_pending", 32'(q_pending), 32'd0);

      // single A write to R5
      @(posedge clk);
      #1;
      a_if.valid = 1'b1;
      a_if.addr  = 5'd5;
      a_if.data  = 32'hDEADBEEF;
      q_addr     = 5'd5;
      @(posedge clk);
      #1;
      a_if.valid = 1'b0;
      @(negedge clk);
      chk("t1_pend0", 32'(q_pending), 32'd1);
      chk("t1_w0", 32'(Reg_w), 32'd0);
      @(negedge clk);
      chk("t1_w1", 32'(Reg_w), 32'd1);
      chk("t1_addr", 32'(Rd_addr), 32'd5);
      chk("t1_data", Rd_data, 32'hDEADBEEF);
      chk("t1_pend1", 32'(q_pending), 32'd1);
      @(negedge clk);
      chk("t1_w2", 32'(Reg_w), 32'd0);
      chk("t1_pend2", 32'(q_pending), 32'd0);
      chk("t1_rf5", rf[5], 32'hDEADBEEF);

      // write to R0 is swallowed
      q_addr = 5'd0;
      @(posedge clk);
      #1;
      a_if.valid = 1'b1;
      a_if.addr  = 5'd0;
      a_if.data  = 32'h1;
      @(negedge clk);
      chk("t2_ready", 32'(a_if.ready), 32'd1);
      @(posedge clk);
      #1;
      a_if.valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t2_w", 32'(Reg_w), 32'd0);
         chk("t2_pend", 32'(q_pending), 32'd0);
      end
      chk("t2_rf0", rf[0], 32'd0);

      // both ports busy: A 1..8, B 9..16
      clear_stim();
      q_addr = 5'd9;
      for (int i = 0; i < 8; i++) begin
         sa_a.push_back(5'(i + 1));
         sa_d.push_back(32'hA300_0000 + 32'(i));
         sb_a.push_back(5'(i + 9));
         sb_d.push_back(32'hB300_0000 + 32'(i));
      end
      stream(60);
`ifdef RF_WB_RR_ARB_EN
      for (int i = 0; i < 8; i++) begin
         exp_a.push_back(5'(i + 1));
         exp_a.push_back(5'(i + 9));
      end
`else
      for (int i = 0; i < 16; i++) exp_a.push_back(5'(i + 1));
`endif
      chk("t3_count", 32'(ret_a.size()), 32'd16);
      foreach (exp_a[i]) begin
         if (i < ret_a.size()) chk("t3_order", 32'(ret_a[i]), 32'(exp_a[i]));
      end

      // longer streams: pointer wrap, back-pressure, per-port order
      clear_stim();
      q_addr = 5'd18;
      for (int i = 0; i < 10; i++) begin
         sa_a.push_back(5'((i % 7) + 17));
         sa_d.push_back(32'hA400_0000 + 32'(i));
         sb_a.push_back(5'((i % 5) + 1));
         sb_d.push_back(32'hB400_0000 + 32'(i));
      end
      stream(80);
      foreach (ret_d[i]) begin
         if (ret_d[i][31:24] == 8'hA4) got_a.push_back(ret_d[i]);
         if (ret_d[i][31:24] == 8'hB4) got_b.push_back(ret_d[i]);
      end
      chk("t4_cnt_a", 32'(got_a.size()), 32'd10);
      chk("t4_cnt_b", 32'(got_b.size()), 32'd10);
      foreach (got_a[i]) chk("t4_ord_a", got_a[i], 32'hA400_0000 + 32'(i));
      foreach (got_b[i]) chk("t4_ord_b", got_b[i], 32'hB400_0000 + 32'(i));

      // reset in the middle of a burst
      clear_stim();
      @(posedge clk);
      #1;
      a_if.valid = 1'b1;
      a_if.addr  = 5'd7;
      a_if.data  = 32'h7777_0000;
      b_if.valid = 1'b1;
      b_if.addr  = 5'd11;
      b_if.data  = 32'hBBBB_0000;
      q_addr     = 5'd11;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("t5_pre_pend", 32'(q_pending), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_Reg_w", 32'(Reg_w), 32'd0);
      chk("t5_Rd_addr", 32'(Rd_addr), 32'd0);
      chk("t5_Rd_data", Rd_data, 32'd0);
      chk("t5_pend", 32'(q_pending), 32'd0);
      a_if.valid = 1'b0;
      b_if.valid = 1'b0;
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t5_no_stale", 32'(Reg_w), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Shares the single write port of the 32×32 register file between two writeback requesters: port A (single-cycle ALU path) and port B (multi-cycle unit, e.g. load/mul). Each port has a small holding FIFO with valid/ready handshake. A registered output stage drives the register file's `Reg_w`/`Rd_addr`/`Rd_data` at one write per cycle. A pending-write query lets the issue logic detect RAW hazards against buffered writes.

## Interface
Parameters:
- `BUF_DEPTH`, 2: entries per port FIFO; power of two, 2..8.

Ports:
- `clk`  input  1  system clock; all state updates on posedge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `a_valid`  input  1  port A write request.
- `a_ready`  output  1  port A FIFO not full.
- `a_addr`  input  5  port A destination register.
- `a_data`  input  32  port A write data.
- `b_valid`, `b_ready`, `b_addr`, `b_data`: same as port A, for port B.
- `Reg_w`  output  1  register-file write enable, registered.
- `Rd_addr`  output  5  register-file write address, registered.
- `Rd_data`  output  32  register-file write data, registered.
- `q_addr`  input  5  hazard query address.
- `q_pending`  output  1  a write to `q_addr` is buffered or in the output stage; combinational.

## Operation
- **Accept:** port X accepts on posedge when `x_valid && x_ready`. `x_ready = (count_x != BUF_DEPTH)`. `x_ready` is a function of state only; no combinational path from `x_valid`.
- **FIFO:**
  - Each FIFO has read/write pointers of `$clog2(BUF_DEPTH)` bits that wrap modulo `BUF_DEPTH`.
  - `count_x` is `$clog2(BUF_DEPTH)+1` bits.
  - A push and a pop in the same cycle leave `count` unchanged.
  - A full FIFO still pops. `ready` reflects the pre-edge count, so there is no same-cycle refill when full.
- **Grant:** each cycle, if either FIFO is non-empty, exactly one head is popped into the output stage. The port is chosen by the arbitration policy (see Configuration).
- **Output stage:**
  - On a pop, `Rd_addr`/`Rd_data` load the head entry.
  - `Reg_w` is set to 1 iff the popped `addr != 0`. Writes to R0 are consumed silently; R0 is never written.
  - With no pop: `Reg_w` = 0; `Rd_addr`/`Rd_data` hold their previous values.
- **Ordering:**
  - Within a port, writes retire in acceptance order.
  - Across ports, no ordering is guaranteed. Issue logic uses `q_pending` to serialise same-register writes.
- **q_pending:** 1 iff `q_addr != 0` and any valid FIFO entry of either port, or the output stage with `Reg_w` = 1, has `addr == q_addr`.
- **Reset** (asserted at any time, including mid-burst):
  - Both FIFOs empty; all buffered writes are discarded.
  - `Reg_w` = 0, `Rd_addr` = 0, `Rd_data` = 0.
  - `a_ready` = `b_ready` = 1 after deassertion; `q_pending` = 0.
  - Round-robin pointer set to "A preferred".

## Timing
- **Latency:** an entry accepted at edge N into an empty FIFO with no contention is popped at edge N+1. `Reg_w` is high between edges N+1 and N+2. The register file latches it on the negedge inside that cycle, so the data is readable from the following half-cycle.
- **Throughput:** one register-file write per cycle total; one accept per port per cycle.
- **Contended cycle:** the loser's head waits at least one cycle. The loser's `ready` drops only if its FIFO is full.
- **Pending window:** `q_pending` for an accepted write asserts from edge N (acceptance) through edge N+2 (output stage retires).

## Configuration
- `RF_WB_RR_ARB_EN` defined: round-robin arbitration.
  - On contention, grant the port not granted on the most recent contended cycle.
  - The pointer changes only on contended grants.
  - No port waits more than 1 contended cycle.
- `RF_WB_RR_ARB_EN` undefined: fixed priority, A over B. B is granted only when A's FIFO is empty. Starvation of B is acceptable in this mode.

## Test plan
- Single A write, addr 5, data 0xDEADBEEF, idle B.
  - `Reg_w`=1, `Rd_addr`=5, `Rd_data`=0xDEADBEEF exactly one cycle after acceptance.
  - Register file R5 = 0xDEADBEEF after the next negedge.
  - `q_pending(5)` = 1 for 2 cycles, then 0.
- Write to addr 0 with data 0x1.
  - Handshake completes; `Reg_w` stays 0 throughout; `q_pending(0)` = 0.
- A and B both valid every cycle for 8 cycles (A addr 1..8, B addr 9..16).
  - With the macro: outputs alternate A,B,A,B…, and `ready` drops once each FIFO fills (count=2).
  - Without the macro: addr 1..8 retire first, then 9..16.
- Back-pressure on a full FIFO with simultaneous pop.
  - `a_ready`=0 in the full cycle; no entry is lost or duplicated.
  - Sequence retires in order after wrap-around of the FIFO pointers.
- Assert `rst_n`=0 mid-burst with both FIFOs full.
  - Outputs go to 0 immediately (asynchronous); `q_pending`=0.
  - After release, no stale write appears on `Reg_w`.
